mem_req_arbiter: RTL

- Shares the single cache-to-AXI bridge request port between the instruction-cache refill path and the data-cache refill, writeback and uncached path.
- Owns one bus transaction at a time, end to end: grant, issue, wait for completion, return the response.
- Sits between the cache subsystem and the AXI bridge, inside the core top.
- Round-robin grant by default, so neither cache can starve the other.

---
 rtl/mem_arb_pkg.sv | 16 +
 rtl/mem_req_arbiter_if.sv | 58 +++++
 rtl/rr_arbiter2.sv | 23 ++
 rtl/mem_req_arbiter.sv | 167 ++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types and sizing for the cache-to-bridge request arbiter.
package mem_arb_pkg;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} arb_state_e;
    typedef enum logic {OWN_IC, OWN_DC} owner_e;

    localparam int DEF_BLOCK_WORDS = 4;
    localparam int DEF_ADDR_W      = 32;

    function automatic int bw_of(input int words);
        return 32 * words;
    endfunction

    localparam int BW = bw_of(DEF_BLOCK_WORDS);

endpackage

// File: rtl/mem_req_arbiter_if.sv
// Cache, bridge and response signals of mem_req_arbiter; slave = arbiter side, master = environment side.
interface mem_req_arbiter_if #(
    parameter int BLOCK_WORDS = 4,
    parameter int ADDR_W      = 32
);
    localparam int BW = 32 * BLOCK_WORDS;

    logic              ic_req_valid;
    logic              ic_req_ready;
    logic [ADDR_W-1:0] ic_addr;
    logic              ic_cached;
    logic [BW-1:0]     ic_rblock;
    logic [31:0]       ic_rword;
    logic              ic_resp_valid;

    logic              dc_req_valid;
    logic              dc_req_ready;
    logic              dc_we;
    logic [ADDR_W-1:0] dc_addr;
    logic              dc_cached;
    logic [BW-1:0]     dc_wblock;
    logic [31:0]       dc_wword;
    logic [3:0]        dc_wstrb;
    logic [BW-1:0]     dc_rblock;
    logic [31:0]       dc_rword;
    logic              dc_resp_valid;

    logic              bus_req_valid;
    logic              bus_req_ready;
    logic              bus_we;
    logic [ADDR_W-1:0] bus_addr;
    logic              bus_cached;
    logic [BW-1:0]     bus_wblock;
    logic [31:0]       bus_wword;
    logic [3:0]        bus_wstrb;
    logic [BW-1:0]     bus_rblock;
    logic [31:0]       bus_rword;
    logic              bus_done;

    modport slave (
        input  ic_req_valid, ic_addr, ic_cached,
        input  dc_req_valid, dc_we, dc_addr, dc_cached, dc_wblock, dc_wword, dc_wstrb,
        input  bus_req_ready, bus_rblock, bus_rword, bus_done,
        output ic_req_ready, ic_rblock, ic_rword, ic_resp_valid,
        output dc_req_ready, dc_rblock, dc_rword, dc_resp_valid,
        output bus_req_valid, bus_we, bus_addr, bus_cached, bus_wblock, bus_wword, bus_wstrb
    );

    modport master (
        output ic_req_valid, ic_addr, ic_cached,
        output dc_req_valid, dc_we, dc_addr, dc_cached, dc_wblock, dc_wword, dc_wstrb,
        output bus_req_ready, bus_rblock, bus_rword, bus_done,
        input  ic_req_ready, ic_rblock, ic_rword, ic_resp_valid,
        input  dc_req_ready, dc_rblock, dc_rword, dc_resp_valid,
        input  bus_req_valid, bus_we, bus_addr, bus_cached, bus_wblock, bus_wword, bus_wstrb
    );

endinterface

// File: rtl/rr_arbiter2.sv
// Two-way grant: round robin on last_grant, or fixed dcache priority when ARB_DCACHE_PRIO_EN is defined.
module rr_arbiter2
    import mem_arb_pkg::*;
(
    input  logic   req_ic_i,
    input  logic   req_dc_i,
    input  owner_e last_grant_i,
    output logic   gnt_ic_o,
    output logic   gnt_dc_o
);

`ifdef ARB_DCACHE_PRIO_EN
    logic unused_last_grant;
    assign unused_last_grant = (last_grant_i == OWN_DC);
    assign gnt_dc_o = req_dc_i;
    assign gnt_ic_o = req_ic_i & ~req_dc_i;
`else
    // On a tie the side that did not win last time gets the bus.
    assign gnt_ic_o = req_ic_i & (~req_dc_i | (last_grant_i == OWN_DC));
    assign gnt_dc_o = req_dc_i & (~req_ic_i | (last_grant_i == OWN_IC));
`endif

endmodule

// File: rtl/mem_req_arbiter.sv
// Shares the bridge port between icache and dcache, one transaction at a time.
// Build option: ARB_DCACHE_PRIO_EN selects fixed dcache priority instead of round robin.
//
// state | meaning
// IDLE  | no owner; grant a waiting requester and latch its payload
// ISSUE | bus_req_valid high with latched payload until bus_req_ready
// WAIT  | request accepted by bridge; waiting for bus_done
// RESP  | one-cycle resp_valid to the owner; no grant this cycle
module mem_req_arbiter
    import mem_arb_pkg::*;
#(
    parameter int BLOCK_WORDS = DEF_BLOCK_WORDS,
    parameter int ADDR_W      = DEF_ADDR_W
) (
    input logic              clk,
    input logic              rstn,
    mem_req_arbiter_if.slave io
);

    localparam int LW = bw_of(BLOCK_WORDS);

    arb_state_e        state_q, state_d;
    owner_e            owner_q, owner_d;
    owner_e            last_q, last_d;
    logic              bus_we_q, bus_we_d;
    logic [ADDR_W-1:0] bus_addr_q, bus_addr_d;
    logic              bus_cached_q, bus_cached_d;
    logic [LW-1:0]     bus_wblock_q, bus_wblock_d;
    logic [31:0]       bus_wword_q, bus_wword_d;
    logic [3:0]        bus_wstrb_q, bus_wstrb_d;
    logic [LW-1:0]     ic_rblock_q, ic_rblock_d;
    logic [31:0]       ic_rword_q, ic_rword_d;
    logic [LW-1:0]     dc_rblock_q, dc_rblock_d;
    logic [31:0]       dc_rword_q, dc_rword_d;
    logic              gnt_ic, gnt_dc;
    logic              ic_ready, dc_ready;
    logic              capture;

    rr_arbiter2 u_rr_arbiter2 (
        .req_ic_i     (io.ic_req_valid),
        .req_dc_i     (io.dc_req_valid),
        .last_grant_i (last_q),
        .gnt_ic_o     (gnt_ic),
        .gnt_dc_o     (gnt_dc)
    );

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q      <= IDLE;
            owner_q      <= OWN_IC;
            last_q       <= OWN_DC;
            bus_we_q     <= 1'b0;
            bus_addr_q   <= '0;
            bus_cached_q <= 1'b0;
            bus_wblock_q <= '0;
            bus_wword_q  <= '0;
            bus_wstrb_q  <= '0;
            ic_rblock_q  <= '0;
            ic_rword_q   <= '0;
            dc_rblock_q  <= '0;
            dc_rword_q   <= '0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            last_q       <= last_d;
            bus_we_q     <= bus_we_d;
            bus_addr_q   <= bus_addr_d;
            bus_cached_q <= bus_cached_d;
            bus_wblock_q <= bus_wblock_d;
            bus_wword_q  <= bus_wword_d;
            bus_wstrb_q  <= bus_wstrb_d;
            ic_rblock_q  <= ic_rblock_d;
            ic_rword_q   <= ic_rword_d;
            dc_rblock_q  <= dc_rblock_d;
            dc_rword_q   <= dc_rword_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        last_d       = last_q;
        bus_we_d     = bus_we_q;
        bus_addr_d   = bus_addr_q;
        bus_cached_d = bus_cached_q;
        bus_wblock_d = bus_wblock_q;
        bus_wword_d  = bus_wword_q;
        bus_wstrb_d  = bus_wstrb_q;
        ic_rblock_d  = ic_rblock_q;
        ic_rword_d   = ic_rword_q;
        dc_rblock_d  = dc_rblock_q;
        dc_rword_d   = dc_rword_q;
        ic_ready     = 1'b0;
        dc_ready     = 1'b0;
        capture      = 1'b0;

        case (state_q)
            IDLE: begin
                if (gnt_ic) begin
                    ic_ready     = 1'b1;
                    bus_we_d     = 1'b0;
                    bus_addr_d   = io.ic_addr;
                    bus_cached_d = io.ic_cached;
                    bus_wblock_d = '0;
                    bus_wword_d  = '0;
                    bus_wstrb_d  = '0;
                    owner_d      = OWN_IC;
                    last_d       = OWN_IC;
                    state_d      = ISSUE;
                end else if (gnt_dc) begin
                    dc_ready     = 1'b1;
                    bus_we_d     = io.dc_we;
                    bus_addr_d   = io.dc_addr;
                    bus_cached_d = io.dc_cached;
                    bus_wblock_d = io.dc_wblock;
                    bus_wword_d  = io.dc_wword;
                    bus_wstrb_d  = io.dc_wstrb;
                    owner_d      = OWN_DC;
                    last_d       = OWN_DC;
                    state_d      = ISSUE;
                end
            end
            ISSUE: begin
                // A bridge may finish in the same cycle it accepts; skip WAIT then.
                if (io.bus_req_ready) begin
                    capture = io.bus_done;
                    state_d = io.bus_done ? RESP : WAIT;
                end
            end
            WAIT: begin
                if (io.bus_done) begin
                    capture = 1'b1;
                    state_d = RESP;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        if (capture) begin
            if (owner_q == OWN_IC) begin
                ic_rblock_d = io.bus_rblock;
                ic_rword_d  = io.bus_rword;
            end else begin
                dc_rblock_d = io.bus_rblock;
                dc_rword_d  = io.bus_rword;
            end
        end
    end

    assign io.ic_req_ready  = ic_ready;
    assign io.dc_req_ready  = dc_ready;
    assign io.ic_resp_valid = (state_q == RESP) && (owner_q == OWN_IC);
    assign io.dc_resp_valid = (state_q == RESP) && (owner_q == OWN_DC);
    assign io.ic_rblock     = ic_rblock_q;
    assign io.ic_rword      = ic_rword_q;
    assign io.dc_rblock     = dc_rblock_q;
    assign io.dc_rword      = dc_rword_q;
    assign io.bus_req_valid = (state_q == ISSUE);
    assign io.bus_we        = bus_we_q;
    assign io.bus_addr      = bus_addr_q;
    assign io.bus_cached    = bus_cached_q;
    assign io.bus_wblock    = bus_wblock_q;
    assign io.bus_wword     = bus_wword_q;
    assign io.bus_wstrb     = bus_wstrb_q;

endmodule
